if_id_buffer: RTL

IF_ID_BUFFER -- requirements
Module: if_id_buffer

---
 rtl/all_pkgs.sv | 36 +++
 rtl/ifid_entry_reg.sv | 46 ++++
 rtl/if_id_buffer.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/all_pkgs.sv
`default_nettype none
// ============================================================================
// Package     : all_pkgs
// Description : Shared constants and types for the IF/ID pipeline buffer.
//               WIDTH      - default PC / instruction width
//               NOP_INSTR  - instruction shown to decode when nothing is held
//               ifid_state_e - occupancy state of the 2-entry buffer
// Revision    : 1.0 - initial release
// ============================================================================
package all_pkgs;

  localparam int          WIDTH     = 32;
  // addi x0, x0, 0 -- canonical RISC-V NOP
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Explicit 2-bit encoding; the value equals the number of held entries,
  // which lets occupancy be read straight off the state.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } ifid_state_e;

  // Entry count for a given state. The unused encoding reads as empty.
  function automatic logic [1:0] state_occupancy(input ifid_state_e s);
    logic [1:0] occ;
    case (s)
      ST_ONE:  occ = 2'd1;
      ST_FULL: occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage : all_pkgs
`default_nettype wire

// File: rtl/ifid_entry_reg.sv
`default_nettype none
// ============================================================================
// Module      : ifid_entry_reg
// Description : One {pc, instr} storage slot of the IF/ID buffer. Loads on
//               load_i, otherwise holds; cleared asynchronously to zero.
// Ports       : clk_i    - clock, rising edge
//               rst_ni   - asynchronous active-low clear
//               load_i   - capture pc_i / instr_i on this edge
//               pc_i     - PC to store
//               instr_i  - instruction word to store
//               pc_o     - stored PC
//               instr_o  - stored instruction word
// Revision    : 1.0 - initial release
// ============================================================================
module ifid_entry_reg #(
  parameter int WIDTH = all_pkgs::WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] pc_i,
  input  logic [WIDTH-1:0] instr_i,
  output logic [WIDTH-1:0] pc_o,
  output logic [WIDTH-1:0] instr_o
);

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] instr_q;

  // Data only moves on load_i, so an X on the fetch bus while nothing is
  // pushed never reaches the stored entry.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q    <= '0;
      instr_q <= '0;
    end else if (load_i) begin
      pc_q    <= pc_i;
      instr_q <= instr_i;
    end
  end

  assign pc_o    = pc_q;
  assign instr_o = instr_q;

endmodule : ifid_entry_reg
`default_nettype wire

// File: rtl/if_id_buffer.sv
`default_nettype none
// ============================================================================
// Module      : if_id_buffer
// Description : 2-entry in-order skid FIFO between fetch and decode. Both
//               handshake outputs come from registered state only, so there
//               is no combinational path from decode back to fetch.
//               if_ready is inverted by the fetch stage to form its stall.
// Ports       : clk        - clock, rising edge
//               rst        - asynchronous active-low reset
//               flush      - discard all buffered entries
//               if_valid   - fetch presents a valid pc/instr pair
//               if_pc      - fetched PC
//               if_instr   - fetched instruction word
//               if_ready   - buffer accepts a push this cycle
//               id_valid   - head entry presented to decode
//               id_pc      - head PC (0 when empty)
//               id_instr   - head instruction (NOP_INSTR when empty)
//               id_ready   - decode consumes the head this cycle
//               occupancy  - number of held entries, 0..2
//               bubble_cnt - saturating count of decode-starved cycles
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_buffer
  import all_pkgs::ifid_state_e;
  import all_pkgs::ST_EMPTY;
  import all_pkgs::ST_ONE;
  import all_pkgs::ST_FULL;
  import all_pkgs::state_occupancy;
#(
  parameter int WIDTH = all_pkgs::WIDTH,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             if_valid,
  input  logic [WIDTH-1:0] if_pc,
  input  logic [WIDTH-1:0] if_instr,
  output logic             if_ready,
  output logic             id_valid,
  output logic [WIDTH-1:0] id_pc,
  output logic [WIDTH-1:0] id_instr,
  input  logic             id_ready,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam logic [WIDTH-1:0] NOP_W = WIDTH'(all_pkgs::NOP_INSTR);

  ifid_state_e      state_q;
  ifid_state_e      state_d;

  logic             push;
  logic             pop;

  logic             head_load;
  logic             head_from_tail;
  logic             tail_load;

  logic [WIDTH-1:0] head_pc_d;
  logic [WIDTH-1:0] head_instr_d;
  logic [WIDTH-1:0] head_pc_q;
  logic [WIDTH-1:0] head_instr_q;
  logic [WIDTH-1:0] tail_pc_q;
  logic [WIDTH-1:0] tail_instr_q;

  logic [CNT_W-1:0] bubble_q;
  logic [CNT_W-1:0] bubble_d;

  // --------------------------------------------------------------------------
  // Handshake: purely a function of the registered state
  // --------------------------------------------------------------------------
  assign if_ready = (state_q != ST_FULL);
  assign id_valid = (state_q != ST_EMPTY);

  assign push = if_valid && if_ready;
  assign pop  = id_valid && id_ready;

  // --------------------------------------------------------------------------
  // Next-state and storage-control logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d        = state_q;
    head_load      = 1'b0;
    head_from_tail = 1'b0;
    tail_load      = 1'b0;

    if (flush) begin
      // Flush wins over any same-cycle push or pop; stale storage is left
      // in place and is masked at the outputs while EMPTY.
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (push) begin
            head_load = 1'b1;
            state_d   = ST_ONE;
          end
        end

        ST_ONE: begin
          case ({push, pop})
            2'b10: begin
              tail_load = 1'b1;
              state_d   = ST_FULL;
            end
            2'b01: begin
              state_d = ST_EMPTY;
            end
            2'b11: begin
              // Head is consumed this edge, so the incoming entry goes
              // straight into the head slot and occupancy stays at one.
              head_load = 1'b1;
              state_d   = ST_ONE;
            end
            default: begin
              state_d = ST_ONE;
            end
          endcase
        end

        ST_FULL: begin
          // if_ready is low here, so no push can be in flight.
          if (pop) begin
            head_load      = 1'b1;
            head_from_tail = 1'b1;
            state_d        = ST_ONE;
          end
        end

        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  assign head_pc_d    = head_from_tail ? tail_pc_q    : if_pc;
  assign head_instr_d = head_from_tail ? tail_instr_q : if_instr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // Entry storage
  // --------------------------------------------------------------------------
  ifid_entry_reg #(
    .WIDTH (WIDTH)
  ) u_head (
    .clk_i   (clk),
    .rst_ni  (rst),
    .load_i  (head_load),
    .pc_i    (head_pc_d),
    .instr_i (head_instr_d),
    .pc_o    (head_pc_q),
    .instr_o (head_instr_q)
  );

  ifid_entry_reg #(
    .WIDTH (WIDTH)
  ) u_tail (
    .clk_i   (clk),
    .rst_ni  (rst),
    .load_i  (tail_load),
    .pc_i    (if_pc),
    .instr_i (if_instr),
    .pc_o    (tail_pc_q),
    .instr_o (tail_instr_q)
  );

  // --------------------------------------------------------------------------
  // Decode-side outputs: head storage, masked to a NOP while empty
  // --------------------------------------------------------------------------
  assign id_pc     = (state_q == ST_EMPTY) ? '0    : head_pc_q;
  assign id_instr  = (state_q == ST_EMPTY) ? NOP_W : head_instr_q;
  assign occupancy = state_occupancy(state_q);

  // --------------------------------------------------------------------------
  // Bubble counter: decode was ready but had nothing to take
  // --------------------------------------------------------------------------
  always_comb begin
    bubble_d = bubble_q;
    if (!flush && id_ready && !id_valid && (bubble_q != '1)) begin
      bubble_d = bubble_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bubble_q <= '0;
    end else begin
      bubble_q <= bubble_d;
    end
  end

  assign bubble_cnt = bubble_q;

endmodule : if_id_buffer
`default_nettype wire
